// File: rtl/ddr3_reset_sequencer.sv
// ddr3_reset_sequencer: power-up sequencer releasing fabric reset, DDR3 RESET#, CKE and calibration start in order
//   clk          sequencer clock, independent of the PLL
//   resetn       asynchronous active-low reset
//   gsr          global startup hold (async, active high)
//   pll_locked   PLL lock (async)
//   calib_done   controller calibration complete (async)
//   restart      one-cycle request to rerun the sequence from READY/ERROR
//   rst_sync_n   fabric logic reset, active low
//   ddr_reset_n  DDR3 RESET#
//   ddr_cke      DDR3 CKE
//   calib_start  one-cycle calibration start pulse
//   ready        sequence complete
//   error        calibration timeout
//   state        current FSM encoding
module ddr3_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int DDR_RESET_CYCLES     = 40000,
    parameter int CKE_DELAY_CYCLES     = 100000,
    parameter int CALIB_TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       gsr,
    input  logic       pll_locked,
    input  logic       calib_done,
    input  logic       restart,
    output logic       rst_sync_n,
    output logic       ddr_reset_n,
    output logic       ddr_cke,
    output logic       calib_start,
    output logic       ready,
    output logic       error,
    output logic [2:0] state
);
    localparam int MAX_A = LOCK_STABLE_CYCLES > DDR_RESET_CYCLES ? LOCK_STABLE_CYCLES : DDR_RESET_CYCLES;
    localparam int MAX_B = CKE_DELAY_CYCLES > CALIB_TIMEOUT_CYCLES ? CKE_DELAY_CYCLES : CALIB_TIMEOUT_CYCLES;
    localparam int MAX_C = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int CW = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] LS_LD = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] DR_LD = CW'(DDR_RESET_CYCLES - 1);
    localparam logic [CW-1:0] CK_LD = CW'(CKE_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] CT_LD = CW'(CALIB_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        HOLD, WAIT_LOCK, LOCK_STABLE, DDR_RESET, CKE_WAIT, CALIB, READY, ERROR
    } st_t;

    st_t           st, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    gsr_q, lock_q, cal_q;
    logic          gsr_s, lock_s, cal_s, cnt_z;

    assign gsr_s  = gsr_q[1];
    assign lock_s = lock_q[1];
    assign cal_s  = cal_q[1];
    assign cnt_z  = cnt == '0;
    assign state  = st;

    // Aborts override the per-state transitions; each timed state loads N-1 on entry
    // and leaves on the cycle the counter reads zero.
    always_comb begin
        nxt     = st;
        cnt_nxt = cnt - 1'b1;
        if (gsr_s) begin
            nxt     = HOLD;
            cnt_nxt = '0;
        end else if (!lock_s && st >= LOCK_STABLE) begin
            nxt     = WAIT_LOCK;
            cnt_nxt = '0;
        end else if (restart && st >= READY) begin
            nxt     = WAIT_LOCK;
            cnt_nxt = '0;
        end else begin
            case (st)
                HOLD:        begin nxt = WAIT_LOCK; cnt_nxt = '0; end
                WAIT_LOCK:   begin nxt = lock_s ? LOCK_STABLE : WAIT_LOCK; cnt_nxt = lock_s ? LS_LD : '0; end
                LOCK_STABLE: begin nxt = cnt_z ? DDR_RESET : LOCK_STABLE; cnt_nxt = cnt_z ? DR_LD : cnt - 1'b1; end
                DDR_RESET:   begin nxt = cnt_z ? CKE_WAIT : DDR_RESET; cnt_nxt = cnt_z ? CK_LD : cnt - 1'b1; end
                CKE_WAIT:    begin nxt = cnt_z ? CALIB : CKE_WAIT; cnt_nxt = cnt_z ? CT_LD : cnt - 1'b1; end
                CALIB:       begin nxt = cal_s ? READY : (cnt_z ? ERROR : CALIB); cnt_nxt = cnt_z ? '0 : cnt - 1'b1; end
                READY:       begin nxt = READY; cnt_nxt = '0; end
                ERROR:       begin nxt = ERROR; cnt_nxt = '0; end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move with the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gsr_q       <= '0;
            lock_q      <= '0;
            cal_q       <= '0;
            st          <= HOLD;
            cnt         <= '0;
            rst_sync_n  <= 1'b0;
            ddr_reset_n <= 1'b0;
            ddr_cke     <= 1'b0;
            calib_start <= 1'b0;
            ready       <= 1'b0;
            error       <= 1'b0;
        end else begin
            gsr_q       <= {gsr_q[0], gsr};
            lock_q      <= {lock_q[0], pll_locked};
            cal_q       <= {cal_q[0], calib_done};
            st          <= nxt;
            cnt         <= cnt_nxt;
            rst_sync_n  <= nxt inside {DDR_RESET, CKE_WAIT, CALIB, READY};
            ddr_reset_n <= nxt inside {CKE_WAIT, CALIB, READY};
            ddr_cke     <= nxt inside {CALIB, READY};
            calib_start <= nxt == CALIB && st != CALIB;
            ready       <= nxt == READY;
            error       <= nxt == ERROR;
        end
    end
endmodule

// File: tb/tb_ddr3_reset_sequencer.sv
// tb_ddr3_reset_sequencer: directed and random checks of the DDR3 reset sequencer against a timing model
module tb_ddr3_reset_sequencer;
    localparam int LS = 8;
    localparam int DR = 16;
    localparam int CK = 12;
    localparam int CT = 64;

    logic       clk, resetn, gsr, pll_locked, calib_done, restart;
    logic       rst_sync_n, ddr_reset_n, ddr_cke, calib_start, ready, error;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    // model: phase, cycle of entry into the phase, running edge count, 2-edge input delay lines
    int         ph, ent, cyc;
    logic [1:0] gd_l, ld_l, cd_l;
    logic       e_cs;
    int         m_ls, m_rs, m_dr, m_ck, m_cs, m_rdy;
    int         e0, cd_cyc;

    ddr3_reset_sequencer #(
        .LOCK_STABLE_CYCLES(LS),
        .DDR_RESET_CYCLES(DR),
        .CKE_DELAY_CYCLES(CK),
        .CALIB_TIMEOUT_CYCLES(CT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .gsr(gsr),
        .pll_locked(pll_locked),
        .calib_done(calib_done),
        .restart(restart),
        .rst_sync_n(rst_sync_n),
        .ddr_reset_n(ddr_reset_n),
        .ddr_cke(ddr_cke),
        .calib_start(calib_start),
        .ready(ready),
        .error(error),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    function automatic int dur(input int p);
        return p == 2 ? LS : p == 3 ? DR : p == 4 ? CK : CT;
    endfunction

    // Phase advances by elapsed-time arithmetic: a timed phase lasts dur() edges after entry.
    task automatic model_edge();
        int   nph;
        logic g, l, c;
        g = gd_l[1];
        l = ld_l[1];
        c = cd_l[1];
        cyc++;
        nph = ph;
        if (g) nph = 0;
        else if (!l && ph >= 2) nph = 1;
        else if (restart && ph >= 6) nph = 1;
        else if (ph == 0) nph = 1;
        else if (ph == 1 && l) nph = 2;
        else if (ph >= 2 && ph <= 4 && cyc - ent == dur(ph)) nph = ph + 1;
        else if (ph == 5 && c) nph = 6;
        else if (ph == 5 && cyc - ent == CT) nph = 7;
        e_cs = nph == 5 && ph != 5;
        if (nph != ph) ent = cyc;
        ph = nph;
        gd_l = {gd_l[0], gsr};
        ld_l = {ld_l[0], pll_locked};
        cd_l = {cd_l[0], calib_done};
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 32'(state), ph);
        chk("rst_sync_n", 32'(rst_sync_n), 32'(ph >= 3 && ph <= 6));
        chk("ddr_reset_n", 32'(ddr_reset_n), 32'(ph >= 4 && ph <= 6));
        chk("ddr_cke", 32'(ddr_cke), 32'(ph == 5 || ph == 6));
        chk("calib_start", 32'(calib_start), 32'(e_cs));
        chk("ready", 32'(ready), 32'(ph == 6));
        chk("error", 32'(error), 32'(ph == 7));
        if (m_ls < 0 && state == 3'd2) m_ls = cyc;
        if (m_rs < 0 && rst_sync_n) m_rs = cyc;
        if (m_dr < 0 && ddr_reset_n) m_dr = cyc;
        if (m_ck < 0 && ddr_cke) m_ck = cyc;
        if (m_cs < 0 && calib_start) m_cs = cyc;
        if (m_rdy < 0 && ready) m_rdy = cyc;
    endtask

    task automatic clr_marks();
        m_ls = -1; m_rs = -1; m_dr = -1; m_ck = -1; m_cs = -1; m_rdy = -1;
    endtask

    task automatic wait_st(input int s, input int lim, input string tag);
        for (int i = 0; i < lim && 32'(state) != s; i++) step();
        chk(tag, 32'(state), s);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #2;
        chk("rst_state", 32'(state), 0);
        chk("rst_rst_sync_n", 32'(rst_sync_n), 0);
        chk("rst_ddr_reset_n", 32'(ddr_reset_n), 0);
        chk("rst_ddr_cke", 32'(ddr_cke), 0);
        chk("rst_calib_start", 32'(calib_start), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_error", 32'(error), 0);
        ph = 0; ent = 0; e_cs = 1'b0;
        gd_l = '0; ld_l = '0; cd_l = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1; gsr = 1'b1; pll_locked = 1'b0; calib_done = 1'b0; restart = 1'b0;
        cyc = 0;
        clr_marks();
        #1;
        do_reset();

        // full power-up sequence
        repeat ($urandom_range(2, 5)) step();
        gsr = 1'b0;
        repeat ($urandom_range(1, 4)) step();
        clr_marks();
        pll_locked = 1'b1;
        wait_st(5, 200, "reach_calib");
        repeat (4) step();
        calib_done = 1'b1;
        cd_cyc = cyc;
        wait_st(6, 20, "reach_ready");
        chk("ls_len", 32'(m_rs - m_ls), LS);
        chk("dr_len", 32'(m_dr - m_rs), DR);
        chk("ck_len", 32'(m_ck - m_dr), CK);
        chk("cs_with_cke", 32'(m_cs - m_ck), 0);
        chk("ready_lat", 32'(m_rdy - cd_cyc), 3);
        repeat (3) step();

        // lock loss in CKE_WAIT, then full rerun ending in calibration timeout
        calib_done = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        wait_st(4, 100, "reach_cke_wait");
        repeat ($urandom_range(1, 6)) step();
        pll_locked = 1'b0;
        repeat (10) step();
        chk("unlock_state", 32'(state), 1);
        chk("unlock_ddr_reset_n", 32'(ddr_reset_n), 0);
        chk("unlock_rst_sync_n", 32'(rst_sync_n), 0);
        clr_marks();
        pll_locked = 1'b1;
        wait_st(5, 200, "relock_calib");
        chk("relock_ls_len", 32'(m_rs - m_ls), LS);
        chk("relock_dr_len", 32'(m_dr - m_rs), DR);
        chk("relock_ck_len", 32'(m_ck - m_dr), CK);
        e0 = cyc;
        wait_st(7, 100, "reach_error");
        chk("timeout_len", 32'(cyc - e0), CT);
        chk("error_set", 32'(error), 1);
        chk("error_cke", 32'(ddr_cke), 0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_state", 32'(state), 1);
        chk("restart_error", 32'(error), 0);

        // restart ignored in LOCK_STABLE; calib_done landing on the timeout cycle
        clr_marks();
        wait_st(2, 10, "reach_ls");
        repeat ($urandom_range(1, 5)) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        wait_st(3, 20, "reach_ddr_reset");
        chk("ls_len_restart", 32'(m_rs - m_ls), LS);
        wait_st(5, 100, "reach_calib2");
        repeat (CT - 3) step();
        calib_done = 1'b1;
        repeat (3) step();
        chk("edge_calib_state", 32'(state), 6);
        chk("edge_calib_error", 32'(error), 0);

        // gsr in READY, then async reset mid-DDR_RESET
        gsr = 1'b1;
        repeat (3) step();
        chk("gsr_state", 32'(state), 0);
        chk("gsr_ready", 32'(ready), 0);
        gsr = 1'b0;
        calib_done = 1'b0;
        wait_st(3, 100, "reach_ddr_reset2");
        repeat ($urandom_range(1, 8)) step();
        do_reset();

        // random input activity checked every cycle against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) gsr = ~gsr;
            if ($urandom_range(0, 14) == 0) pll_locked = ~pll_locked;
            if ($urandom_range(0, 19) == 0) calib_done = ~calib_done;
            restart = $urandom_range(0, 29) == 0;
            step();
        end
        restart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
